// File: rtl/aes_pipeline_sequencer.sv
// aes_pipeline_sequencer
//   Run controller for the image encrypt/decrypt pipeline. For each run it
//   sequences key/IV configuration, a settle delay, the reader start and the
//   wait for completion. It counts AES output beats, checks the count when the
//   writer finishes, and reports busy/done/error. Each waiting phase has a
//   watchdog.
//
// Ports
//   clk, rst_n        clock; asynchronous active-low reset
//   go, force_config  run request (taken in IDLE only); force a reconfigure
//   abort             synchronous abort, highest priority
//   start_config      one-cycle pulse to the AXI-Lite config master
//   config_done       config complete (level or pulse, acted on at rising edge)
//   reader_start      one-cycle pulse to the image reader
//   reader_done       reader status (not used for sequencing)
//   writer_done       writer complete (level or pulse, acted on at rising edge)
//   beat_valid/ready  AES output stream handshake (monitored)
//   busy, done        not idle; one-cycle success pulse
//   error, err_code   sticky error flag and cause
//   configured        key/IV loaded since reset
//   blocks_out        beats counted this run, saturating at IMAGE_DEPTH
module aes_pipeline_sequencer #(
  parameter int unsigned IMAGE_DEPTH    = 64,
  parameter int unsigned CNT_W          = 7,
  parameter int unsigned SETTLE_CYCLES  = 20,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             go,
  input  logic             force_config,
  input  logic             abort,
  output logic             start_config,
  input  logic             config_done,
  output logic             reader_start,
  input  logic             reader_done,
  input  logic             writer_done,
  input  logic             beat_valid,
  input  logic             beat_ready,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [2:0]       err_code,
  output logic             configured,
  output logic [CNT_W-1:0] blocks_out
);

  localparam logic [2:0] StIdle     = 3'd0;
  localparam logic [2:0] StCfgStart = 3'd1;
  localparam logic [2:0] StCfgWait  = 3'd2;
  localparam logic [2:0] StSettle   = 3'd3;
  localparam logic [2:0] StRdStart  = 3'd4;
  localparam logic [2:0] StRun      = 3'd5;
  localparam logic [2:0] StDone     = 3'd6;
  localparam logic [2:0] StErr      = 3'd7;

  localparam logic [2:0] ErrCfgTimeout = 3'b001;
  localparam logic [2:0] ErrRunTimeout = 3'b010;
  localparam logic [2:0] ErrCount      = 3'b011;
  localparam logic [2:0] ErrAbort      = 3'b100;

  localparam logic [CNT_W-1:0] DepthCnt  = CNT_W'(IMAGE_DEPTH);
  localparam logic [CNT_W:0]   DepthEff  = (CNT_W + 1)'(IMAGE_DEPTH);
  localparam logic [31:0]      WdogLast  = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0]      SettleEnd = 32'(SETTLE_CYCLES - 1);

  logic [2:0]       r_state, w_state_d;
  logic             r_cfg_done_q, r_wr_done_q;
  logic [31:0]      r_wdog, w_wdog_d;
  logic [31:0]      r_settle, w_settle_d;
  logic [CNT_W-1:0] r_blocks, w_blocks_d;
  logic             r_configured, w_configured_d;
  logic             r_error, w_error_d;
  logic [2:0]       r_err_code, w_err_code_d;

  logic             w_cfg_rise, w_wr_rise, w_beat, w_wdog_hit, w_abortable;
  logic [CNT_W:0]   w_eff_count;

  // Reader completion is status only; kept visible for waves.
  logic w_unused_reader_done;
  assign w_unused_reader_done = reader_done;

  // Edge detection so sticky levels from a previous run are ignored.
  assign w_cfg_rise  = config_done & ~r_cfg_done_q;
  assign w_wr_rise   = writer_done & ~r_wr_done_q;
  assign w_beat      = beat_valid & beat_ready;
  assign w_wdog_hit  = (r_wdog == WdogLast);
  // A beat landing in the same cycle as the writer_done rise still counts.
  assign w_eff_count = {1'b0, r_blocks} + {{CNT_W{1'b0}}, w_beat};
  // DONE/ERR are already terminal, so abort has nothing left to stop there.
  assign w_abortable = (r_state == StCfgStart) || (r_state == StCfgWait) ||
                       (r_state == StSettle) || (r_state == StRdStart) ||
                       (r_state == StRun);

  always_comb begin
    w_state_d      = r_state;
    w_wdog_d       = r_wdog;
    w_settle_d     = r_settle;
    w_blocks_d     = r_blocks;
    w_configured_d = r_configured;
    w_error_d      = r_error;
    w_err_code_d   = r_err_code;

    case (r_state)
      StIdle: begin
        if (go) begin
          w_error_d    = 1'b0;
          w_err_code_d = 3'b000;
          w_blocks_d   = '0;
          w_state_d    = (!r_configured || force_config) ? StCfgStart : StRdStart;
        end
      end
      StCfgStart: begin
        w_wdog_d  = '0;
        w_state_d = StCfgWait;
      end
      StCfgWait: begin
        if (w_cfg_rise) begin
          w_configured_d = 1'b1;
          w_settle_d     = '0;
          w_state_d      = StSettle;
        end else if (w_wdog_hit) begin
          w_configured_d = 1'b0;
          w_error_d      = 1'b1;
          w_err_code_d   = ErrCfgTimeout;
          w_state_d      = StErr;
        end else begin
          w_wdog_d = r_wdog + 32'd1;
        end
      end
      StSettle: begin
        if (r_settle == SettleEnd) begin
          w_state_d = StRdStart;
        end else begin
          w_settle_d = r_settle + 32'd1;
        end
      end
      StRdStart: begin
        w_wdog_d  = '0;
        w_state_d = StRun;
      end
      StRun: begin
        if (w_beat && (r_blocks != DepthCnt)) begin
          w_blocks_d = r_blocks + CNT_W'(1);
        end
        if (w_wr_rise) begin
          if (w_eff_count == DepthEff) begin
            w_state_d = StDone;
          end else begin
            w_error_d    = 1'b1;
            w_err_code_d = ErrCount;
            w_state_d    = StErr;
          end
        end else if (w_wdog_hit) begin
          w_error_d    = 1'b1;
          w_err_code_d = ErrRunTimeout;
          w_state_d    = StErr;
        end else begin
          w_wdog_d = r_wdog + 32'd1;
        end
      end
      StDone:  w_state_d = StIdle;
      StErr:   w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase

    // Abort overrides completion and timeout decisions made above.
    if (abort && w_abortable) begin
      w_error_d    = 1'b1;
      w_err_code_d = ErrAbort;
      w_state_d    = StErr;
      // Key load may have been interrupted mid-write.
      if (r_state == StCfgWait) begin
        w_configured_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= StIdle;
      r_cfg_done_q <= 1'b0;
      r_wr_done_q  <= 1'b0;
      r_wdog       <= '0;
      r_settle     <= '0;
      r_blocks     <= '0;
      r_configured <= 1'b0;
      r_error      <= 1'b0;
      r_err_code   <= 3'b000;
    end else begin
      r_state      <= w_state_d;
      r_cfg_done_q <= config_done;
      r_wr_done_q  <= writer_done;
      r_wdog       <= w_wdog_d;
      r_settle     <= w_settle_d;
      r_blocks     <= w_blocks_d;
      r_configured <= w_configured_d;
      r_error      <= w_error_d;
      r_err_code   <= w_err_code_d;
    end
  end

  assign busy         = (r_state != StIdle);
  assign start_config = (r_state == StCfgStart);
  assign reader_start = (r_state == StRdStart);
  assign done         = (r_state == StDone);
  assign error        = r_error;
  assign err_code     = r_err_code;
  assign configured   = r_configured;
  assign blocks_out   = r_blocks;

endmodule
